// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcodes, register-port control codes and sequencer states.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'h0,
        ALU_OP_SUB  = 4'h1,
        ALU_OP_AND  = 4'h2,
        ALU_OP_OR   = 4'h3,
        ALU_OP_XOR  = 4'h4,
        ALU_OP_NOT  = 4'h5,
        ALU_OP_SHL  = 4'h6,
        ALU_OP_SHR  = 4'h7,
        ALU_OP_ASHR = 4'h8
    } alu_op_t;

    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'b00,
        REG_OP_READ  = 2'b01,
        REG_OP_WRITE = 2'b10
    } reg_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } seq_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= ALU_OP_ASHR;
    endfunction

    // Only ADD and SUB drive a meaningful overflow; for every other op the ALU output is X.
    function automatic logic op_sets_ovf(input logic [3:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/regfile.sv
// NREGS x WIDTH register file: three asynchronous read ports, one write port.
// Build option REGFILE_ZERO_R0_EN makes r0 a constant zero (writes dropped, reads return 0).
module regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    input  logic [AW-1:0]    raddr_c,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem [NREGS];
    logic             wr_ok;

`ifdef REGFILE_ZERO_R0_EN
    assign wr_ok   = we && (waddr != '0);
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
    assign rdata_c = (raddr_c == '0) ? '0 : mem[raddr_c];
`else
    assign wr_ok   = we;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];
`endif

    // NOTE: the array is reset because architectural registers must read 0 after reset;
    // this forces flops rather than a RAM macro, which is fine at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Register file front-end for the ALU: IDLE -> READ -> EXEC command sequencer with write-back and flags.
// Build option REGFILE_ZERO_R0_EN is honoured inside regfile.
module alu_operand_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    output logic             done,
    output logic             err,
    input  logic             ld_en,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_mode,
    output reg_op_t          alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             flag_zero,
    output logic             flag_ovf
);

    seq_state_t       state;
    logic [3:0]       op_q;
    logic [AW-1:0]    dst_q, src_a_q, src_b_q;
    logic [WIDTH-1:0] rf_a, rf_b;
    logic             busy, accept, wb_en, rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    assign busy      = (state != IDLE);
    assign cmd_ready = !busy;
    assign ld_ready  = !busy;
    assign accept    = cmd_valid && !busy;
    assign wb_en     = (state == EXEC) && op_is_legal(op_q);

    // Loads only happen in IDLE and write-back only in EXEC, so the shared port never collides.
    assign rf_we    = wb_en || (ld_en && !busy);
    assign rf_waddr = wb_en ? dst_q : ld_addr;
    assign rf_wdata = wb_en ? alu_result : ld_data;

    regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (src_a_q),
        .raddr_b (src_b_q),
        .raddr_c (rd_addr),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .rdata_c (rd_data)
    );

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= READ;
                READ:    state <= EXEC;
                EXEC:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
        end else if (accept) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            err       <= 1'b0;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
        end else begin
            done <= (state == EXEC);
            err  <= (state == EXEC) && !op_is_legal(op_q);
            if (wb_en) begin
                flag_zero <= alu_zero;
                flag_ovf  <= op_sets_ovf(op_q) ? alu_overflow : 1'b0;
            end
        end
    end

    // Operands come straight from the register file; nothing writes it during READ/EXEC,
    // so they stay stable through both cycles.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_mode    = ALU_OP_NOT;
        alu_control = REG_OP_NONE;
        if (state == READ || state == EXEC) begin
            alu_a       = rf_a;
            alu_b       = rf_b;
            alu_mode    = op_q;
            alu_control = (state == READ) ? REG_OP_READ : REG_OP_WRITE;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: behavioural ALU on the alu_* ports, table vectors, corner sequences, random run.
module tb_alu_operand_sequencer;
    import cpu_pkg::*;

`ifdef REGFILE_ZERO_R0_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, done, err;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src_a, cmd_src_b, ld_addr, rd_addr;
    logic       ld_en, ld_ready;
    logic [7:0] ld_data, rd_data, alu_a, alu_b, alu_result;
    logic [3:0] alu_mode;
    reg_op_t    alu_control;
    logic       alu_overflow, alu_zero, flag_zero, flag_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_rf [4];
    logic       model_zero, model_ovf;

    always #10 clk = ~clk;

    alu_operand_sequencer #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .done(done), .err(err),
        .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_control(alu_control),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .flag_zero(flag_zero), .flag_ovf(flag_ovf)
    );

    // Returns {overflow, result}. ADD overflow is carry-out, SUB overflow is borrow;
    // other ops return overflow 1 to imitate the ALU's undefined output there.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_OP_ADD:  return {1'b0, a} + {1'b0, b};
            ALU_OP_SUB:  return {(a < b), a - b};
            ALU_OP_AND:  return {1'b1, a & b};
            ALU_OP_OR:   return {1'b1, a | b};
            ALU_OP_XOR:  return {1'b1, a ^ b};
            ALU_OP_NOT:  return {1'b1, ~a};
            ALU_OP_SHL:  return {1'b1, a << 1};
            ALU_OP_SHR:  return {1'b1, a >> 1};
            ALU_OP_ASHR: return {1'b1, a[7], a[7:1]};
            default:     return 9'h100;
        endcase
    endfunction

    // Behavioural ALU: latches operands on the falling edge during READ, drives outputs during WRITE.
    logic [7:0] alu_la, alu_lb;
    logic [3:0] alu_lm;
    logic [8:0] alu_out;
    always @(negedge clk) begin
        if (alu_control == REG_OP_READ) begin
            alu_la <= alu_a;
            alu_lb <= alu_b;
            alu_lm <= alu_mode;
        end
    end
    always_comb begin
        alu_out      = alu_ref(alu_lm, alu_la, alu_lb);
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_zero     = 1'b0;
        if (alu_control == REG_OP_WRITE) begin
            alu_result   = alu_out[7:0];
            alu_overflow = alu_out[8];
            alu_zero     = (alu_out[7:0] == 8'h00);
        end
    end

    function automatic logic [7:0] exp_read(input logic [1:0] a);
        if (R0Z && a == 2'd0) return 8'h00;
        return model_rf[a];
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [7:0] d);
        if (!(R0Z && a == 2'd0)) model_rf[a] = d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        model_zero = 1'b0;
        model_ovf  = 1'b0;
    endfunction

    // Applies one retired command to the model; illegal ops change nothing.
    function automatic void model_apply(input logic [3:0] op, input logic [1:0] d,
                                        input logic [1:0] a, input logic [1:0] b);
        logic [8:0] r;
        if (op > 4'd8) return;
        r = alu_ref(op, exp_read(a), exp_read(b));
        model_write(d, r[7:0]);
        model_zero = (r[7:0] == 8'h00);
        model_ovf  = (op == ALU_OP_ADD || op == ALU_OP_SUB) ? r[8] : 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check($sformatf("%s rf[%0d]", tag, i), rd_data, exp_read(2'(i)));
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, " flag_zero"}, flag_zero, model_zero);
        check({tag, " flag_ovf"}, flag_ovf, model_ovf);
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        check("ld_ready in idle", ld_ready, 1'b1);
        @(posedge clk); #1;
        ld_en = 1'b0;
        model_write(a, d);
    endtask

    // Issues one command and checks every cycle up to the cycle after the done pulse.
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] d,
                           input logic [1:0] a, input logic [1:0] b);
        logic [7:0] va, vb;
        va = exp_read(a);
        vb = exp_read(b);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = d; cmd_src_a = a; cmd_src_b = b;
        check({tag, " cmd_ready"}, cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check({tag, " read ctrl"}, alu_control, REG_OP_READ);
        check({tag, " read mode"}, alu_mode, op);
        check({tag, " read a"}, alu_a, va);
        check({tag, " read b"}, alu_b, vb);
        check({tag, " done early"}, done, 1'b0);
        @(posedge clk); #1;
        check({tag, " exec ctrl"}, alu_control, REG_OP_WRITE);
        check({tag, " exec a held"}, alu_a, va);
        check({tag, " done early2"}, done, 1'b0);
        @(posedge clk); #1;
        check({tag, " done"}, done, 1'b1);
        check({tag, " err"}, err, (op > 4'd8));
        check({tag, " idle ctrl"}, alu_control, REG_OP_NONE);
        model_apply(op, d, a, b);
        check_flags(tag);
        check_regs(tag);
        @(posedge clk); #1;
        check({tag, " done pulse"}, done, 1'b0);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] dst, sa, sb;
        logic [7:0] va, vb, res;
        logic       z, o;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{ALU_OP_ADD,  2'd3, 2'd1, 2'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[1] = '{ALU_OP_ADD,  2'd0, 2'd1, 2'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{ALU_OP_XOR,  2'd2, 2'd1, 2'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{ALU_OP_SUB,  2'd1, 2'd1, 2'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{ALU_OP_SUB,  2'd2, 2'd1, 2'd3, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        vecs[5] = '{ALU_OP_ASHR, 2'd1, 2'd2, 2'd3, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b0};
        vecs[6] = '{ALU_OP_NOT,  2'd3, 2'd1, 2'd2, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{ALU_OP_SHL,  2'd0, 2'd1, 2'd2, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{ALU_OP_AND,  2'd3, 2'd2, 2'd1, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        model_reset();
        #1;
        check("reset alu_a", alu_a, 8'h00);
        check("reset alu_b", alu_b, 8'h00);
        check("reset alu_mode", alu_mode, ALU_OP_NOT);
        check("reset alu_control", alu_control, REG_OP_NONE);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check_flags("reset");
        check_regs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("cmd_ready after reset", cmd_ready, 1'b1);
        check("ld_ready after reset", ld_ready, 1'b1);

        // Table vectors: load operands, run the command, compare against the listed result.
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].sa, vecs[i].va);
            do_load(vecs[i].sb, vecs[i].vb);
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb);
            rd_addr = vecs[i].dst;
            #1;
            check($sformatf("vec%0d result", i), rd_data,
                  (R0Z && vecs[i].dst == 2'd0) ? 8'h00 : vecs[i].res);
            check($sformatf("vec%0d zero", i), flag_zero, vecs[i].z);
            check($sformatf("vec%0d ovf", i), flag_ovf, vecs[i].o);
        end

        // Back-to-back: valid held, second command consumes the first one's result.
        do_load(2'd1, 8'h10);
        do_load(2'd2, 8'h22);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = ALU_OP_ADD; cmd_dst = 2'd3; cmd_src_a = 2'd1; cmd_src_b = 2'd2;
        @(posedge clk); #1;
        cmd_op = ALU_OP_SUB; cmd_dst = 2'd2; cmd_src_a = 2'd3; cmd_src_b = 2'd1;
        check("b2b busy", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("b2b busy2", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("b2b done1", done, 1'b1);
        check("b2b ready", cmd_ready, 1'b1);
        model_apply(ALU_OP_ADD, 2'd3, 2'd1, 2'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b second accepted", cmd_ready, 1'b0);
        check("b2b second a", alu_a, exp_read(2'd3));
        check("b2b done1 pulse", done, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b done2", done, 1'b1);
        model_apply(ALU_OP_SUB, 2'd2, 2'd3, 2'd1);
        check_flags("b2b");
        check_regs("b2b");

        // Illegal op with a load attempt while busy: nothing may change.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'hB; cmd_dst = 2'd1; cmd_src_a = 2'd2; cmd_src_b = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
        check("illegal ld_ready", ld_ready, 1'b0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        check("illegal done early", done, 1'b0);
        @(posedge clk); #1;
        check("illegal done", done, 1'b1);
        check("illegal err", err, 1'b1);
        check_flags("illegal");
        check_regs("illegal");
        @(posedge clk); #1;
        check("illegal err pulse", err, 1'b0);

        // Reset while in EXEC aborts the command.
        do_load(2'd1, 8'h40);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = ALU_OP_ADD; cmd_dst = 2'd2; cmd_src_a = 2'd1; cmd_src_b = 2'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #3;
        check("pre-reset exec", alu_control, REG_OP_WRITE);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid reset ctrl", alu_control, REG_OP_NONE);
        check("mid reset alu_a", alu_a, 8'h00);
        check("mid reset mode", alu_mode, ALU_OP_NOT);
        check("mid reset done", done, 1'b0);
        check("mid reset ready", cmd_ready, 1'b1);
        check_flags("mid reset");
        check_regs("mid reset");
        @(posedge clk); #1;
        check("mid reset no done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset no done", done, 1'b0);
        check_regs("post reset");
        do_load(2'd1, 8'h12);
        do_load(2'd2, 8'h34);
        run_cmd("post reset add", ALU_OP_ADD, 2'd3, 2'd1, 2'd2);

        // Random commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(2'($urandom_range(0, 3)), 8'($urandom));
            run_cmd($sformatf("rand%0d", i), 4'($urandom_range(0, 10)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
